// File: rtl/call_stack_ctrl.sv
// Return-address stack sequencer: turns CALL/RET requests into stack push/pop
// cycles, tracks occupancy, and hands the destination address back to the PC.
module call_stack_ctrl #(
    parameter int width = 8,
    parameter int depth = 2
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             call,
    input  logic             ret,
    input  logic [width-1:0] target,
    input  logic [width-1:0] pc_in,
    input  logic [width-1:0] stk_q,
    input  logic             stk_full,
    output logic             stk_en,
    output logic             stk_con,
    output logic [width-1:0] stk_d,
    output logic [width-1:0] pc_out,
    output logic             pc_load,
    output logic             done,
    output logic             busy,
    output logic             err,
    output logic [depth:0]   level
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_PUSH = 3'd1;
    localparam logic [2:0] ST_POP  = 3'd2;
    localparam logic [2:0] ST_WAIT = 3'd3;
    localparam logic [2:0] ST_LOAD = 3'd4;
    localparam logic [2:0] ST_ERR  = 3'd5;

    localparam logic [depth:0] LEVEL_MAX  = {1'b1, {depth{1'b0}}};
    localparam logic [depth:0] LEVEL_ZERO = {(depth+1){1'b0}};
    localparam logic [depth:0] LEVEL_ONE  = {{depth{1'b0}}, 1'b1};

    logic [2:0]       state_r;
    logic [2:0]       next_s;
    logic [width-1:0] ra_r;
    logic [width-1:0] ta_r;
    logic [depth:0]   level_r;
    logic             err_r;
    logic             stk_en_r;
    logic             stk_con_r;
    logic             pc_load_r;
    logic             done_r;
    logic             busy_r;

    assign stk_en  = stk_en_r;
    assign stk_con = stk_con_r;
    assign stk_d   = ra_r;
    assign pc_out  = ta_r;
    assign pc_load = pc_load_r;
    assign done    = done_r;
    assign busy    = busy_r;
    assign err     = err_r;
    assign level   = level_r;

    // Next-state decode; call takes priority over ret when both are raised.
    always_comb begin
        next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (call) begin
                    if ((level_r == LEVEL_MAX) || stk_full) begin
                        next_s = ST_ERR;
                    end else begin
                        next_s = ST_PUSH;
                    end
                end else if (ret) begin
                    if (level_r == LEVEL_ZERO) begin
                        next_s = ST_ERR;
                    end else begin
                        next_s = ST_POP;
                    end
                end else begin
                    next_s = ST_IDLE;
                end
            end
            ST_PUSH: next_s = ST_LOAD;
            ST_POP:  next_s = ST_WAIT;
            ST_WAIT: next_s = ST_LOAD;
            ST_LOAD: next_s = ST_IDLE;
            ST_ERR:  next_s = ST_IDLE;
            default: next_s = ST_IDLE;
        endcase
    end

    // State register plus Moore outputs registered from the upcoming state.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_r   <= ST_IDLE;
            stk_en_r  <= 1'b0;
            stk_con_r <= 1'b0;
            ra_r      <= {width{1'b0}};
            pc_load_r <= 1'b0;
            done_r    <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= next_s;
            stk_en_r  <= (next_s == ST_PUSH) || (next_s == ST_POP);
            stk_con_r <= (next_s == ST_POP);
            // ra doubles as the stack data line, so it is only non-zero in PUSH
            ra_r      <= (next_s == ST_PUSH) ? pc_in : {width{1'b0}};
            pc_load_r <= (next_s == ST_LOAD);
            done_r    <= (next_s == ST_LOAD) || (next_s == ST_ERR);
            busy_r    <= (next_s != ST_IDLE);
        end
    end

    // Target address: CALL destination on accept, popped address after WAIT.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            ta_r <= {width{1'b0}};
        end else if ((state_r == ST_IDLE) && (next_s == ST_PUSH)) begin
            ta_r <= target;
        end else if (state_r == ST_WAIT) begin
            ta_r <= stk_q;
        end else begin
            ta_r <= ta_r;
        end
    end

    // Occupancy count mirrors the stack; guards in IDLE keep it from wrapping.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            level_r <= LEVEL_ZERO;
        end else if (state_r == ST_PUSH) begin
            level_r <= level_r + LEVEL_ONE;
        end else if (state_r == ST_POP) begin
            level_r <= level_r - LEVEL_ONE;
        end else begin
            level_r <= level_r;
        end
    end

    // Sticky error flag, cleared only by clr.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            err_r <= 1'b0;
        end else if (state_r == ST_ERR) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

endmodule

// File: tb/tb_call_stack_ctrl.sv
// Directed bench for call_stack_ctrl with a small behavioural 4-entry stack.
module tb_call_stack_ctrl;

    logic       clk;
    logic       clr;
    logic       call;
    logic       ret;
    logic [7:0] target;
    logic [7:0] pc_in;
    logic [7:0] stk_q;
    logic       stk_full;
    logic       stk_en;
    logic       stk_con;
    logic [7:0] stk_d;
    logic [7:0] pc_out;
    logic       pc_load;
    logic       done;
    logic       busy;
    logic       err;
    logic [2:0] level;

    int checks;
    int errors;

    logic [7:0] mem [4];
    logic [2:0] sp;

    call_stack_ctrl #(.width(8), .depth(2)) dut (
        .clk(clk), .clr(clr), .call(call), .ret(ret), .target(target),
        .pc_in(pc_in), .stk_q(stk_q), .stk_full(stk_full), .stk_en(stk_en),
        .stk_con(stk_con), .stk_d(stk_d), .pc_out(pc_out), .pc_load(pc_load),
        .done(done), .busy(busy), .err(err), .level(level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign stk_full = (sp == 3'd4);

    // Reference stack: data_out updates on the pop edge, cleared by clr.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            sp    <= 3'd0;
            stk_q <= 8'h00;
        end else if (stk_en && !stk_con && (sp != 3'd4)) begin
            mem[sp[1:0]] <= stk_d;
            sp           <= sp + 3'd1;
        end else if (stk_en && stk_con && (sp != 3'd0)) begin
            stk_q <= mem[sp[1:0] - 2'd1];
            sp    <= sp - 3'd1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    // CALL (optionally with ret also high); entered and left at a negedge in IDLE.
    task automatic do_call(input logic [7:0] pc, input logic [7:0] tgt,
                           input logic with_ret, input logic [2:0] exp_level);
        call = 1'b1; ret = with_ret; pc_in = pc; target = tgt;
        @(negedge clk);
        call = 1'b0; ret = 1'b0;
        check_eq("push_en", stk_en, 1'b1);
        check_eq("push_con", stk_con, 1'b0);
        check_eq("push_d", stk_d, pc);
        check_eq("push_done", done, 1'b0);
        check_eq("push_busy", busy, 1'b1);
        @(negedge clk);
        check_eq("call_load", pc_load, 1'b1);
        check_eq("call_pc", pc_out, tgt);
        check_eq("call_done", done, 1'b1);
        check_eq("call_en", stk_en, 1'b0);
        @(negedge clk);
        check_eq("call_level", level, exp_level);
        check_eq("call_idle", busy, 1'b0);
        check_eq("call_done_off", done, 1'b0);
    endtask

    task automatic do_ret(input logic [7:0] exp_pc, input logic [2:0] exp_level);
        ret = 1'b1;
        @(negedge clk);
        ret = 1'b0;
        check_eq("pop_en", stk_en, 1'b1);
        check_eq("pop_con", stk_con, 1'b1);
        check_eq("pop_d", stk_d, 8'h00);
        @(negedge clk);
        check_eq("wait_en", stk_en, 1'b0);
        check_eq("wait_load", pc_load, 1'b0);
        check_eq("wait_busy", busy, 1'b1);
        @(negedge clk);
        check_eq("ret_load", pc_load, 1'b1);
        check_eq("ret_pc", pc_out, exp_pc);
        check_eq("ret_done", done, 1'b1);
        @(negedge clk);
        check_eq("ret_level", level, exp_level);
        check_eq("ret_idle", busy, 1'b0);
    endtask

    // Rejected request; err_before is the sticky flag value during the ERR cycle.
    task automatic do_err(input logic is_call, input logic err_before, input logic [2:0] exp_level);
        call = is_call; ret = !is_call; pc_in = 8'hEE; target = 8'hDD;
        @(negedge clk);
        call = 1'b0; ret = 1'b0;
        check_eq("err_done", done, 1'b1);
        check_eq("err_en", stk_en, 1'b0);
        check_eq("err_load", pc_load, 1'b0);
        check_eq("err_busy", busy, 1'b1);
        check_eq("err_early", err, err_before);
        @(negedge clk);
        check_eq("err_flag", err, 1'b1);
        check_eq("err_done_off", done, 1'b0);
        check_eq("err_en2", stk_en, 1'b0);
        check_eq("err_level", level, exp_level);
        check_eq("err_idle", busy, 1'b0);
    endtask

    initial begin
        checks = 0; errors = 0;
        clr = 1'b0; call = 1'b0; ret = 1'b0; target = 8'h00; pc_in = 8'h00;
        #1;
        check_eq("rst_level", level, 3'd0);
        check_eq("rst_err", err, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_pc", pc_out, 8'h00);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_load", pc_load, 1'b0);
        check_eq("rst_en", stk_en, 1'b0);
        check_eq("rst_d", stk_d, 8'h00);
        @(negedge clk);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);

        do_call(8'h11, 8'h40, 1'b0, 3'd1);
        do_ret(8'h11, 3'd0);
        check_eq("basic_err", err, 1'b0);

        for (int i = 1; i <= 4; i++) begin
            do_call(8'(i), 8'(8'h80 + i), 1'b0, 3'(i));
        end
        do_err(1'b1, 1'b0, 3'd4);
        check_eq("ovf_pc_hold", pc_out, 8'h84);
        for (int i = 4; i >= 1; i--) begin
            do_ret(8'(i), 3'(i - 1));
        end

        do_err(1'b0, 1'b1, 3'd0);

        do_call(8'h55, 8'h66, 1'b1, 3'd1);

        ret = 1'b1;
        @(negedge clk);
        ret = 1'b0;
        @(negedge clk);
        check_eq("pre_clr_busy", busy, 1'b1);
        check_eq("pre_clr_err", err, 1'b1);
        clr = 1'b0;
        #1;
        check_eq("clr_busy", busy, 1'b0);
        check_eq("clr_err", err, 1'b0);
        check_eq("clr_level", level, 3'd0);
        check_eq("clr_pc", pc_out, 8'h00);
        check_eq("clr_en", stk_en, 1'b0);
        check_eq("clr_load", pc_load, 1'b0);
        check_eq("clr_done", done, 1'b0);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        check_eq("post_clr_load", pc_load, 1'b0);
        check_eq("post_clr_level", level, 3'd0);
        do_err(1'b0, 1'b0, 3'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
